// File: rtl/lsu_pkg.sv
// Shared integer-core defines: ALU opcodes, RV32I load/store funct3 encodings,
// access sizes and the LSU state encoding.
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] carries the access size for both loads and stores.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = offset[0];
      default: mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication, load lane
// selection with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SIZE_B: begin
        st_be    = 4'b0001 << st_offset;
        st_wdata = {4{st_data[7:0]}};
      end
      SIZE_H: begin
        st_be    = 4'b0011 << st_offset;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfword lanes are only ever at offset 0 or 2 for aligned accesses.
  assign ld_byte = ld_rdata[{ld_offset, 3'b000} +: 8];
  assign ld_half = ld_rdata[{ld_offset[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = ld_rdata;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {24'b0, ld_byte};
      F3_LHU:  ld_data = {16'b0, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-bus access, misalignment trap,
// single-cycle load writeback pulse. Only C_XLEN = 32 is supported.
module lsu
  import lsu_pkg::*;
#(
  parameter int C_XLEN = 32
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_load_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [C_XLEN-1:0] req_addr_i,
  input  logic [C_XLEN-1:0] req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              dbus_req_o,
  input  logic              dbus_ack_i,
  output logic              dbus_we_o,
  output logic [3:0]        dbus_be_o,
  output logic [C_XLEN-1:0] dbus_addr_o,
  output logic [C_XLEN-1:0] dbus_wdata_o,
  input  logic              dbus_rvalid_i,
  input  logic [C_XLEN-1:0] dbus_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [C_XLEN-1:0] wb_data_o,
  output logic              misalign_o,
  output logic              misalign_load_o,
  output logic [C_XLEN-1:0] exc_addr_o
);

  lsu_state_e state_q, state_d;

  logic        req_misaligned;
  logic        take;
  logic        raise_misalign;
  logic        bus_done;
  logic        load_done;

  logic        load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [4:0]  rd_q;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign req_ready_o    = (state_q == LSU_IDLE);
  assign req_misaligned = is_misaligned(req_funct3_i[1:0], req_addr_i[1:0]);

  lsu_align u_align (
    .st_size   (req_funct3_i[1:0]),
    .st_offset (req_addr_i[1:0]),
    .st_data   (req_wdata_i),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (funct3_q),
    .ld_offset (offset_q),
    .ld_rdata  (dbus_rdata_i),
    .ld_data   (ld_data)
  );

  // With clk_en_i low nothing is sampled: state_d stays state_q and no strobe fires.
  always_comb begin
    state_d        = state_q;
    take           = 1'b0;
    raise_misalign = 1'b0;
    bus_done       = 1'b0;
    load_done      = 1'b0;
    if (clk_en_i) begin
      case (state_q)
        LSU_IDLE: begin
          if (req_valid_i) begin
            if (req_misaligned) begin
              raise_misalign = 1'b1;
            end else begin
              take    = 1'b1;
              state_d = LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (dbus_ack_i) begin
            bus_done = 1'b1;
            if (!load_q) begin
              state_d = LSU_IDLE;
            end else if (dbus_rvalid_i) begin
              load_done = 1'b1;
              state_d   = LSU_IDLE;
            end else begin
              state_d = LSU_WAIT;
            end
          end
        end
        LSU_WAIT: begin
          if (dbus_rvalid_i) begin
            load_done = 1'b1;
            state_d   = LSU_IDLE;
          end
        end
        default: state_d = LSU_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= LSU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      load_q          <= 1'b0;
      funct3_q        <= 3'b000;
      offset_q        <= 2'b00;
      rd_q            <= 5'd0;
      dbus_req_o      <= 1'b0;
      dbus_we_o       <= 1'b0;
      dbus_be_o       <= 4'b0000;
      dbus_addr_o     <= '0;
      dbus_wdata_o    <= '0;
      wb_valid_o      <= 1'b0;
      wb_rd_o         <= 5'd0;
      wb_data_o       <= '0;
      misalign_o      <= 1'b0;
      misalign_load_o <= 1'b0;
      exc_addr_o      <= '0;
    end else if (clk_en_i) begin
      wb_valid_o <= load_done;
      misalign_o <= raise_misalign;

      if (take || raise_misalign) begin
        load_q   <= req_load_i;
        funct3_q <= req_funct3_i;
        offset_q <= req_addr_i[1:0];
        rd_q     <= req_rd_i;
      end

      if (raise_misalign) begin
        misalign_load_o <= req_load_i;
        exc_addr_o      <= req_addr_i;
      end

      // Bus fields are loaded once at accept and stay frozen until the ack.
      if (take) begin
        dbus_req_o   <= 1'b1;
        dbus_we_o    <= !req_load_i;
        dbus_be_o    <= st_be;
        dbus_addr_o  <= {req_addr_i[C_XLEN-1:2], 2'b00};
        dbus_wdata_o <= st_wdata;
      end else if (bus_done) begin
        dbus_req_o <= 1'b0;
      end

      if (load_done) begin
        wb_rd_o   <= rd_q;
        wb_data_o <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed cases plus randomized traffic against a
// byte-lane reference model and a randomly stalling bus responder.
module tb_lsu;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct {
    logic        load;
    logic [31:0] addr;
  } mis_exp_t;

  logic        clk = 1'b0;
  logic        resetb = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_load = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;

  logic        auto_bus = 1'b0;
  logic        en_rand = 1'b0;
  logic        d_en = 1'b0, r_en = 1'b1;
  logic        d_ack = 1'b0, r_ack = 1'b0;
  logic        d_rvalid = 1'b0, r_rvalid = 1'b0;
  logic [31:0] d_rdata = '0, r_rdata = '0;

  logic        clk_en;
  logic        dbus_ack;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;

  logic        req_ready_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_addr_o;
  logic [31:0] dbus_wdata_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;
  logic        misalign_load_o;
  logic [31:0] exc_addr_o;

  assign clk_en      = en_rand  ? r_en     : d_en;
  assign dbus_ack    = auto_bus ? r_ack    : d_ack;
  assign dbus_rvalid = auto_bus ? r_rvalid : d_rvalid;
  assign dbus_rdata  = auto_bus ? r_rdata  : d_rdata;

  bus_exp_t exp_bus[$];
  wb_exp_t  exp_wb[$];
  mis_exp_t exp_mis[$];
  int total = 0;
  int bad = 0;

  lsu #(.C_XLEN(32)) dut (
    .clk_i           (clk),
    .resetb_i        (resetb),
    .clk_en_i        (clk_en),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready_o),
    .req_load_i      (req_load),
    .req_funct3_i    (req_funct3),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .req_rd_i        (req_rd),
    .dbus_req_o      (dbus_req_o),
    .dbus_ack_i      (dbus_ack),
    .dbus_we_o       (dbus_we_o),
    .dbus_be_o       (dbus_be_o),
    .dbus_addr_o     (dbus_addr_o),
    .dbus_wdata_o    (dbus_wdata_o),
    .dbus_rvalid_i   (dbus_rvalid),
    .dbus_rdata_i    (dbus_rdata),
    .wb_valid_o      (wb_valid_o),
    .wb_rd_o         (wb_rd_o),
    .wb_data_o       (wb_data_o),
    .misalign_o      (misalign_o),
    .misalign_load_o (misalign_load_o),
    .exc_addr_o      (exc_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference model: access size in bytes, lane arithmetic on integers.
  function automatic int acc_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    int     n = acc_bytes(f3);
    int     off = int'(a[1:0]);
    longint v;
    longint span;
    span = longint'(1) << (8 * n);
    v = (longint'(word) >> (8 * off)) % span;
    if (f3[2] == 1'b0 && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = '0;
    int off = int'(a[1:0]);
    int n = acc_bytes(f3);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w = '0;
    int n = acc_bytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata);
    bit done = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_load   = ld;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
    for (int i = 0; i < 300 && !done; i++) begin
      #4;
      if (req_ready_o && clk_en) begin
        done = 1;
        if ((int'(a[1:0]) % acc_bytes(f3)) != 0) begin
          exp_mis.push_back('{ld, a});
        end else begin
          exp_bus.push_back('{{a[31:2], 2'b00}, !ld, model_be(f3, a), model_wdata(f3, wd)});
          if (ld) exp_wb.push_back('{rd, model_load(f3, a, rdata)});
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("issue_accepted", done, 1);
  endtask

  // Monitor: samples just before each rising edge and pops on observed events.
  initial begin
    bus_exp_t eb;
    wb_exp_t  ew;
    mis_exp_t em;
    forever begin
      @(negedge clk);
      #4;
      if (resetb) begin
        if (dbus_req_o) begin
          check("bus_req_expected", exp_bus.size() != 0, 1);
          if (exp_bus.size() != 0) begin
            eb = exp_bus[0];
            check("bus_addr", dbus_addr_o, eb.addr);
            check("bus_we", dbus_we_o, eb.we);
            if (eb.we) begin
              check("bus_be", dbus_be_o, eb.be);
              check("bus_wdata", dbus_wdata_o, eb.wdata);
            end
            if (dbus_ack && clk_en) void'(exp_bus.pop_front());
          end
        end
        if (wb_valid_o && clk_en) begin
          check("wb_expected", exp_wb.size() != 0, 1);
          if (exp_wb.size() != 0) begin
            ew = exp_wb.pop_front();
            check("wb_rd", wb_rd_o, ew.rd);
            check("wb_data", wb_data_o, ew.data);
          end
        end
        if (misalign_o && clk_en) begin
          check("misalign_expected", exp_mis.size() != 0, 1);
          if (exp_mis.size() != 0) begin
            em = exp_mis.pop_front();
            check("misalign_load", misalign_load_o, em.load);
            check("exc_addr", exc_addr_o, em.addr);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (en_rand) r_en = ($urandom_range(0, 9) < 8);
    end
  end

  // Random bus responder: stalls acks, returns read data from mem_word(),
  // and sprinkles stray ack/rvalid while nothing is outstanding.
  initial begin
    bit          pend = 0;
    logic [31:0] paddr = '0;
    forever begin
      @(negedge clk);
      r_ack    = 1'b0;
      r_rvalid = 1'b0;
      r_rdata  = $urandom;
      if (!auto_bus) begin
        pend = 0;
      end else begin
        if (pend) begin
          if ($urandom_range(0, 1) == 1) begin
            r_rvalid = 1'b1;
            r_rdata  = mem_word(paddr);
          end
        end else if (dbus_req_o) begin
          if ($urandom_range(0, 1) == 1) begin
            r_ack = 1'b1;
            if (!dbus_we_o && $urandom_range(0, 2) == 0) begin
              r_rvalid = 1'b1;
              r_rdata  = mem_word(dbus_addr_o);
            end
          end
        end else begin
          r_ack    = ($urandom_range(0, 9) == 0);
          r_rvalid = ($urandom_range(0, 9) == 0);
        end
        #4;
        if (clk_en && resetb) begin
          if (pend && r_rvalid) begin
            pend = 0;
          end else if (!pend && dbus_req_o && r_ack && !dbus_we_o && !r_rvalid) begin
            pend  = 1;
            paddr = dbus_addr_o;
          end
        end
      end
    end
  end

  initial begin
    logic [2:0]  ld_f3[5];
    logic [2:0]  f3;
    logic [31:0] a;
    logic        ld;
    bit          drained;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset, with the clock enable low.
    #2 resetb = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", req_ready_o, 1);
    check("rst_dbus_req", dbus_req_o, 0);
    check("rst_dbus_we", dbus_we_o, 0);
    check("rst_dbus_be", dbus_be_o, 0);
    check("rst_dbus_addr", dbus_addr_o, 0);
    check("rst_dbus_wdata", dbus_wdata_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_exc_addr", exc_addr_o, 0);
    @(negedge clk);
    resetb = 1'b1;
    d_en   = 1'b1;

    // LW 0x100: ack next cycle, rvalid two cycles after the ack.
    issue(1'b1, 3'b010, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF);
    d_ack = 1'b1;
    @(negedge clk) d_ack = 1'b0;
    @(negedge clk);
    @(negedge clk) begin d_rvalid = 1'b1; d_rdata = 32'hDEADBEEF; end
    @(negedge clk) d_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("lw_wb_drained", exp_wb.size(), 0);

    // Sub-word loads with ack and rvalid together.
    issue(1'b1, 3'b000, 32'h103, 32'h0, 5'd1, 32'h80112233);
    d_ack = 1'b1; d_rvalid = 1'b1; d_rdata = 32'h80112233;
    @(negedge clk) begin d_ack = 1'b0; d_rvalid = 1'b0; end
    issue(1'b1, 3'b100, 32'h103, 32'h0, 5'd2, 32'h80112233);
    d_ack = 1'b1; d_rvalid = 1'b1;
    @(negedge clk) begin d_ack = 1'b0; d_rvalid = 1'b0; end
    issue(1'b1, 3'b101, 32'h102, 32'h0, 5'd3, 32'h80112233);
    d_ack = 1'b1; d_rvalid = 1'b1;
    @(negedge clk) begin d_ack = 1'b0; d_rvalid = 1'b0; end
    repeat (3) @(negedge clk);
    check("subword_wb_drained", exp_wb.size(), 0);

    // SH 0x202: replicated halfword on the upper lanes, no writeback.
    issue(1'b0, 3'b001, 32'h202, 32'h0000ABCD, 5'd4, 32'h0);
    #4 check("sh_be_direct", dbus_be_o, 4'b1100);
    @(negedge clk) d_ack = 1'b1;
    @(negedge clk) d_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("sh_bus_drained", exp_bus.size(), 0);

    // Misaligned LW: no bus request, ready stays high.
    issue(1'b1, 3'b010, 32'h101, 32'h0, 5'd5, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #4;
      check("mis_no_dbus_req", dbus_req_o, 0);
      check("mis_ready", req_ready_o, 1);
      @(negedge clk);
    end
    check("mis_drained", exp_mis.size(), 0);

    // LH with a 5-cycle ack stall and the enable low for two cycles.
    issue(1'b1, 3'b001, 32'h106, 32'h0, 5'd6, 32'h87654321);
    for (int i = 0; i < 5; i++) begin
      d_en = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    d_en = 1'b1; d_ack = 1'b1;
    @(negedge clk) begin d_ack = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h87654321; end
    @(negedge clk) begin d_rvalid = 1'b0; d_en = 1'b0; end
    @(negedge clk) d_en = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_wb_drained", exp_wb.size(), 0);

    // Reset while waiting for read data, then stray bus responses.
    issue(1'b1, 3'b010, 32'h300, 32'h0, 5'd9, 32'h11111111);
    d_ack = 1'b1;
    @(negedge clk) d_ack = 1'b0;
    @(negedge clk);
    #1 resetb = 1'b0;
    #1;
    check("rst_wait_dbus_req", dbus_req_o, 0);
    check("rst_wait_ready", req_ready_o, 1);
    exp_bus.delete();
    exp_wb.delete();
    @(negedge clk) resetb = 1'b1;
    d_rvalid = 1'b1; d_ack = 1'b1; d_rdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) begin d_rvalid = 1'b0; d_ack = 1'b0; end
      #4 check("stray_no_wb", wb_valid_o, 0);
    end

    // Reset while the bus request is still up.
    issue(1'b0, 3'b010, 32'h400, 32'h12345678, 5'd0, 32'h0);
    #1 resetb = 1'b0;
    #1 check("rst_req_dbus_req", dbus_req_o, 0);
    exp_bus.delete();
    @(negedge clk) resetb = 1'b1;
    @(negedge clk);

    // Randomized traffic.
    auto_bus = 1'b1;
    en_rand  = 1'b1;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ld = ($urandom_range(0, 9) < 6);
      f3 = ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a  = 32'h1000 + 32'($urandom_range(0, 255));
      issue(ld, f3, a, $urandom, 5'($urandom_range(0, 31)), mem_word({a[31:2], 2'b00}));
    end
    drained = 0;
    for (int i = 0; i < 1000 && !drained; i++) begin
      @(negedge clk);
      drained = (exp_bus.size() == 0) && (exp_wb.size() == 0) &&
                (exp_mis.size() == 0) && req_ready_o;
    end
    check("final_bus_drained", exp_bus.size(), 0);
    check("final_wb_drained", exp_wb.size(), 0);
    check("final_mis_drained", exp_mis.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter C_XLEN, default 32, datapath and address width; only 32 is supported.
REQ-002 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 resetb_i  in  1  asynchronous, active-low reset.
REQ-004 clk_en_i  in  1  pipeline clock enable; state, outputs and handshakes advance only when 1.
REQ-005 req_valid_i  in  1  execute stage presents a load/store.
REQ-006 req_ready_o  out  1  LSU can accept a request.
REQ-007 req_load_i  in  1  1 = load, 0 = store.
REQ-008 req_funct3_i  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
REQ-009 req_addr_i  in  C_XLEN  effective address (ALU result).
REQ-010 req_wdata_i  in  C_XLEN  store data (rs2).
REQ-011 req_rd_i  in  5  load destination register.
REQ-012 dbus_req_o  out  1  data-bus request; dbus_ack_i  in  1  bus accepts request.
REQ-013 dbus_we_o  out  1; dbus_be_o  out  4; dbus_addr_o  out  C_XLEN (word-aligned, bits[1:0]=0); dbus_wdata_o  out  C_XLEN.
REQ-014 dbus_rvalid_i  in  1; dbus_rdata_i  in  C_XLEN  load return data.
REQ-015 wb_valid_o  out  1; wb_rd_o  out  5; wb_data_o  out  C_XLEN  load writeback.
REQ-016 misalign_o  out  1; misalign_load_o  out  1; exc_addr_o  out  C_XLEN  misaligned-access exception.

Function
REQ-017 FSM states: IDLE, REQ, WAIT; req_ready_o = (state==IDLE).
REQ-018 Request accepted when req_valid_i & req_ready_o & clk_en_i; addr, funct3, wdata, rd, load latched.
REQ-019 Misaligned (H with addr[0]=1, W with addr[1:0]!=0): no bus request, state stays IDLE, misalign_o=1 for one cycle next cycle, misalign_load_o=req_load_i, exc_addr_o=req_addr_i.
REQ-020 Aligned accept: IDLE->REQ; dbus_req_o=1 from next cycle, held with stable addr/we/be/wdata until dbus_ack_i.
REQ-021 Store byte enables: SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111; dbus_wdata_o = rs2 byte/halfword replicated across lanes.
REQ-022 Store: REQ + ack -> IDLE; no writeback.
REQ-023 Load: REQ + ack -> WAIT; WAIT + dbus_rvalid_i -> IDLE; ack and rvalid in same cycle -> IDLE directly.
REQ-024 Load data: lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-025 wb_valid_o=1 for exactly one cycle, the cycle after rvalid is sampled, with wb_rd_o and wb_data_o; otherwise 0.
REQ-026 dbus_rvalid_i outside WAIT/REQ-load ignored; dbus_ack_i while dbus_req_o=0 ignored.
REQ-027 clk_en_i=0: FSM holds, dbus_req_o held; bus inputs not sampled that cycle; pulse outputs held.
REQ-028 Throughput: one access outstanding; minimum store 2 cycles, load 2 cycles accept-to-writeback when ack and rvalid coincide.

Reset
REQ-029 resetb_i=0 forces state IDLE, dbus_req_o=0, dbus_we_o=0, dbus_be_o=0, wb_valid_o=0, misalign_o=0, all data/address registers 0, immediately and regardless of clk_en_i.
REQ-030 Reset mid-transaction abandons it; a late rvalid/ack after reset release while IDLE is ignored.

Structure
REQ-031 funct3 load/store encodings and FSM state encodings live in the shared defines header alongside the ALU opcode defines.
REQ-032 Combinational sub-module lsu_align: byte-enable/write-data replication, load lane select and extension; FSM and registers in lsu.

Verification
REQ-033 LW addr 0x100, ack next cycle, rvalid+rdata 0xDEADBEEF two cycles later -> one wb_valid_o pulse, wb_data_o=0xDEADBEEF, correct rd.
REQ-034 LB addr 0x103, rdata 0x80112233 -> wb_data_o=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
REQ-035 SH addr 0x202 wdata 0x0000ABCD -> dbus_addr_o=0x200, dbus_be_o=1100, dbus_wdata_o=0xABCDABCD, dbus_we_o=1, no wb_valid_o.
REQ-036 LW addr 0x101 -> no dbus_req_o, misalign_o pulse, misalign_load_o=1, exc_addr_o=0x101, req_ready_o stays 1.
REQ-037 Load with ack withheld 5 cycles and clk_en_i low 2 cycles -> dbus signals stable throughout; single wb pulse after rvalid.
REQ-038 resetb_i low while in WAIT -> dbus_req_o=0, state IDLE; subsequent stray rvalid produces no wb_valid_o.
